ccip_txn_tracker: RTL
=====================

Name: ccip_txn_tracker

Overview:
Parametrised, synthesisable transaction tracker for CCI-P request/response channels. It sits beside the AFU port and matches each request to its response by tag, per channel. It measures completion latency and flags duplicate-tag, orphan-response and timeout errors. Completion and error records are pushed into an event FIFO that a host-side logger or debug CSR path drains with valid/ready.

Parameters:
NUM_CH, 2, number of independent request/response channels (ch0 = reads, ch1 = writes)
TAG_W, 6, tag width; each channel's tag table has 2^TAG_W entries
TS_W, 32, free-running timestamp width
TIMEOUT, 4096, age in cycles at or above which an outstanding entry is declared timed out; must be < 2^TS_W
EVT_DEPTH, 16, event FIFO depth; power of 2, ≥2

Ports:
clk  in  1  clock
SoftReset  in  1  asynchronous active-high reset
req_valid  in  NUM_CH  request issued on channel i this cycle
req_tag  in  NUM_CH*TAG_W  request tag, channel i in slice i
rsp_valid  in  NUM_CH  response returned on channel i this cycle
rsp_tag  in  NUM_CH*TAG_W  response tag, channel i in slice i
evt_valid  out  1  event FIFO not empty
evt_ready  in  1  consumer pops head when evt_valid&evt_ready
evt_data  out  $bits(trk_evt_t)  head event
outstanding  out  NUM_CH*(TAG_W+1)  live entries per channel
max_latency  out  NUM_CH*TS_W  largest completion latency seen per channel
err_sticky  out  4  {overflow, timeout, orphan, dup}, sticky until reset
evt_drop_cnt  out  16  events lost to arbitration or full FIFO, saturating

Behaviour:
- Reset (async assert, sync deassert): all tag-table valid bits 0, timestamp 0, scan pointers 0, FIFO empty, all outputs 0.
- Timestamp `now` increments every cycle and wraps mod 2^TS_W. Age/latency = (now − issue_ts) mod 2^TS_W, unsigned.
- Response on ch i, tag t:
  - entry valid: clear it, latency = age, emit COMPLETE, update max_latency if greater.
  - entry not valid: emit ORPHAN, set err_sticky[1].
- Request on ch i, tag t:
  - entry already valid: emit DUP, set err_sticky[0], overwrite issue_ts with now.
  - otherwise set valid, issue_ts = now.
- Same cycle, same channel, same tag, req and rsp: the response is processed first against the old state, then the request allocates. Net result: the entry is valid with issue_ts = now, and no DUP is raised.
- Timeout scan: one entry per channel per cycle; the scan pointer increments and wraps at 2^TAG_W.
  - If the scanned entry is valid and age ≥ TIMEOUT: clear it, emit TIMEOUT, set err_sticky[2].
  - If a response or request hits the scanned entry in the same cycle, the scan does nothing for that entry.
  - Worst-case detection = TIMEOUT + 2^TAG_W − 1 cycles.
- outstanding[i]: +1 on allocate from invalid, −1 on each clear. Simultaneous +1/−1 leaves it unchanged. Maximum value 2^TAG_W.
- Event arbitration: at most one FIFO write per cycle.
  - Fixed priority: TIMEOUT > ORPHAN > DUP > COMPLETE, then lower channel index first within a kind.
  - Every losing candidate increments evt_drop_cnt.
  - Event fields: kind (2b), ch, tag, latency (age for TIMEOUT/COMPLETE, 0 otherwise), ts = now.
- FIFO: write and read latency 1 (event visible on evt_valid the cycle after generation).
  - When full, the write is dropped, evt_drop_cnt increments and err_sticky[3] is set.
  - Simultaneous pop and push when full: accepted, no drop.
  - evt_data is stable while evt_valid && !evt_ready.
- evt_drop_cnt saturates at 16'hFFFF.
- Reset mid-operation: all state is discarded, and no events are emitted for outstanding entries.

Decomposition:
- Package ccip_trk_pkg holds:
  - trk_kind_e {COMPLETE=0, DUP=1, ORPHAN=2, TIMEOUT=3}
  - trk_evt_t packed struct {kind, ch[$clog2(NUM_CH)] (min 1 bit), tag[TAG_W], latency[TS_W], ts[TS_W]}, sized from the package default constants
  - the err_sticky bit indices
- Sub-module ccip_trk_evt_fifo: generic synchronous show-ahead FIFO with full/empty, width and depth parameters.
- Tag tables, scan and arbitration stay in the top module, using a generate loop per channel.

Test Plan:
- Req ch0 tag 5 at t=10, rsp ch0 tag 5 at t=37 -> one COMPLETE {ch0, tag5, latency 27}; outstanding[0] goes 1 then 0; max_latency[0]=27.
- Rsp ch1 tag 9 with nothing outstanding -> ORPHAN {ch1, tag9}; err_sticky=4'b0010; outstanding[1] stays 0.
- Req ch0 tag 3 twice, 4 cycles apart, then rsp -> one DUP, then COMPLETE with latency measured from the second request; outstanding peaks at 1.
- TIMEOUT=64, TAG_W=4: req ch1 tag 2, no response -> TIMEOUT event with latency in [64, 79]; entry cleared; a later rsp tag 2 gives ORPHAN.
- Hold evt_ready=0; generate 20 completions on distinct cycles -> 16 events queued, evt_drop_cnt=4, err_sticky[3]=1. Then drain -> events in issue order with correct tags.
- Same cycle: rsp ch0 tag 1 (valid entry) and rsp ch1 tag 4 (invalid) -> ORPHAN ch1 written, COMPLETE ch0 dropped, evt_drop_cnt=1. Also assert SoftReset mid-stream -> all outputs 0 on the next clk edge.

Source files
------------

// File: rtl/ccip_trk_pkg.sv
// Shared types and constants for the CCI-P transaction tracker.
// The event record is sized from the default constants. Instances that use a
// narrower TAG_W or TS_W have their values zero-extended into the record.
package ccip_trk_pkg;

  localparam int NUM_CH_D = 2;
  localparam int TAG_W_D  = 6;
  localparam int TS_W_D   = 32;
  localparam int CH_W     = (NUM_CH_D > 1) ? $clog2(NUM_CH_D) : 1;

  // err_sticky bit positions
  localparam int ERR_DUP      = 0;
  localparam int ERR_ORPHAN   = 1;
  localparam int ERR_TIMEOUT  = 2;
  localparam int ERR_OVERFLOW = 3;

  typedef enum logic [1:0] {
    COMPLETE = 2'd0,
    DUP      = 2'd1,
    ORPHAN   = 2'd2,
    TIMEOUT  = 2'd3
  } trk_kind_e;

  typedef struct packed {
    trk_kind_e           kind;
    logic [CH_W-1:0]     ch;
    logic [TAG_W_D-1:0]  tag;
    logic [TS_W_D-1:0]   latency;
    logic [TS_W_D-1:0]   ts;
  } trk_evt_t;

  // 16-bit counter increment that sticks at all-ones
  function automatic logic [15:0] satAdd16(input logic [15:0] a, input logic [7:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {9'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/ccip_trk_evt_fifo.sv
// Generic show-ahead FIFO: the head entry is presented on rdData whenever the
// FIFO is not empty. A push into a full FIFO is accepted only when a pop
// happens in the same cycle. rdData reads as zero while the FIFO is empty.
module ccip_trk_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [AW:0]      count;
  logic             doWr, doRd;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign doRd   = rdEn && !empty;
  assign doWr   = wrEn && (!full || doRd);
  assign rdData = empty ? '0 : mem[rdPtr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + 1'b1;
      if (doRd) rdPtr <= rdPtr + 1'b1;
      if (doWr && !doRd)      count <= count + 1'b1;
      else if (doRd && !doWr) count <= count - 1'b1;
    end
  end

  // Storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (doWr) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/ccip_txn_tracker.sv
// CCI-P request/response tracker. Per channel it keeps a tag table of issue
// timestamps, matches responses to requests, and sweeps one entry per cycle
// looking for stale requests. At most one event per cycle is pushed into the
// event FIFO; every other event generated that cycle is counted as dropped.
// TAG_W must not exceed the tag field of trk_evt_t (6 bits), and TS_W must
// not exceed its timestamp fields (32 bits).
module ccip_txn_tracker
  import ccip_trk_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int TAG_W     = 6,
  parameter int TS_W      = 32,
  parameter int TIMEOUT   = 4096,
  parameter int EVT_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        SoftReset,
  input  logic [NUM_CH-1:0]           req_valid,
  input  logic [NUM_CH*TAG_W-1:0]     req_tag,
  input  logic [NUM_CH-1:0]           rsp_valid,
  input  logic [NUM_CH*TAG_W-1:0]     rsp_tag,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output trk_evt_t                    evt_data,
  output logic [NUM_CH*(TAG_W+1)-1:0] outstanding,
  output logic [NUM_CH*TS_W-1:0]      max_latency,
  output logic [3:0]                  err_sticky,
  output logic [15:0]                 evt_drop_cnt
);

  localparam int ENTRIES = 2**TAG_W;
  localparam int OUT_W   = TAG_W + 1;
  localparam logic [TS_W-1:0] TO_AGE = TS_W'(TIMEOUT);

  logic [TS_W-1:0] now;

  logic [NUM_CH-1:0]            cmpV, orphV, dupV, toV;
  logic [NUM_CH-1:0][TAG_W-1:0] cmpTag, orphTag, dupTag, toTag;
  logic [NUM_CH-1:0][TS_W-1:0]  cmpLat, toLat;

  // Free-running timestamp, wraps naturally
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) now <= '0;
    else           now <= now + 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    logic [ENTRIES-1:0] entValid;
    logic [TS_W-1:0]    issueTs [ENTRIES];
    logic [TAG_W-1:0]   scanPtr, reqT, rspT;
    logic               reqV, rspV, reqLive, scanBusy;
    logic [TS_W-1:0]    rspAge, scanAge, maxLat;
    logic [OUT_W-1:0]   outCnt;

    assign reqV = req_valid[c];
    assign rspV = rsp_valid[c];
    assign reqT = req_tag[c*TAG_W +: TAG_W];
    assign rspT = rsp_tag[c*TAG_W +: TAG_W];

    assign rspAge  = now - issueTs[rspT];
    assign scanAge = now - issueTs[scanPtr];

    // A response to the same tag retires the entry before the request looks
    // at it, so a same-cycle req+rsp pair re-allocates without a DUP.
    assign reqLive  = entValid[reqT] && !(rspV && (rspT == reqT));
    assign scanBusy = (rspV && (rspT == scanPtr)) || (reqV && (reqT == scanPtr));

    assign cmpV[c]    = rspV && entValid[rspT];
    assign orphV[c]   = rspV && !entValid[rspT];
    assign dupV[c]    = reqV && reqLive;
    assign toV[c]     = entValid[scanPtr] && !scanBusy && (scanAge >= TO_AGE);
    assign cmpTag[c]  = rspT;
    assign orphTag[c] = rspT;
    assign dupTag[c]  = reqT;
    assign toTag[c]   = scanPtr;
    assign cmpLat[c]  = rspAge;
    assign toLat[c]   = scanAge;

    assign outstanding[c*OUT_W +: OUT_W] = outCnt;
    assign max_latency[c*TS_W +: TS_W]   = maxLat;

    // Tag-table valid bits, sweep pointer, live count and latency high-water mark
    always_ff @(posedge clk or posedge SoftReset) begin
      if (SoftReset) begin
        entValid <= '0;
        scanPtr  <= '0;
        outCnt   <= '0;
        maxLat   <= '0;
      end else begin
        scanPtr <= scanPtr + 1'b1;
        if (toV[c])  entValid[scanPtr] <= 1'b0;
        if (cmpV[c]) entValid[rspT]    <= 1'b0;
        if (reqV)    entValid[reqT]    <= 1'b1;
        outCnt <= outCnt + OUT_W'(reqV && !reqLive) - OUT_W'(cmpV[c]) - OUT_W'(toV[c]);
        if (cmpV[c] && (rspAge > maxLat)) maxLat <= rspAge;
      end
    end

    // Issue timestamps, only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
      if (reqV) issueTs[reqT] <= now;
    end
  end

  trk_evt_t    winEvt;
  logic        winV;
  logic [7:0]  candCnt;
  logic [7:0]  dropInc;
  logic        fifoFull, fifoEmpty, overflow;

  // Pick one event: later loops overwrite earlier ones, so the last match is
  // the highest kind at the lowest channel index.
  always_comb begin
    winV    = 1'b0;
    winEvt  = '0;
    candCnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      candCnt = candCnt + 8'(toV[c]) + 8'(orphV[c]) + 8'(dupV[c]) + 8'(cmpV[c]);
    end
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (cmpV[c]) begin
        winV = 1'b1; winEvt.kind = COMPLETE; winEvt.ch = CH_W'(c);
        winEvt.tag = TAG_W_D'(cmpTag[c]); winEvt.latency = TS_W_D'(cmpLat[c]);
      end
    end
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (dupV[c]) begin
        winV = 1'b1; winEvt.kind = DUP; winEvt.ch = CH_W'(c);
        winEvt.tag = TAG_W_D'(dupTag[c]); winEvt.latency = '0;
      end
    end
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (orphV[c]) begin
        winV = 1'b1; winEvt.kind = ORPHAN; winEvt.ch = CH_W'(c);
        winEvt.tag = TAG_W_D'(orphTag[c]); winEvt.latency = '0;
      end
    end
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (toV[c]) begin
        winV = 1'b1; winEvt.kind = ccip_trk_pkg::TIMEOUT; winEvt.ch = CH_W'(c);
        winEvt.tag = TAG_W_D'(toTag[c]); winEvt.latency = TS_W_D'(toLat[c]);
      end
    end
    winEvt.ts = TS_W_D'(now);
  end

  assign overflow  = winV && fifoFull && !evt_ready;
  assign dropInc   = candCnt - {7'd0, winV} + {7'd0, overflow};
  assign evt_valid = !fifoEmpty;

  ccip_trk_evt_fifo #(
    .WIDTH ($bits(trk_evt_t)),
    .DEPTH (EVT_DEPTH)
  ) uEvtFifo (
    .clk    (clk),
    .rst    (SoftReset),
    .wrEn   (winV),
    .wrData (winEvt),
    .rdEn   (evt_ready),
    .rdData (evt_data),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // Sticky error flags and the saturating lost-event counter
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      err_sticky   <= '0;
      evt_drop_cnt <= '0;
    end else begin
      err_sticky   <= err_sticky | {overflow, |toV, |orphV, |dupV};
      evt_drop_cnt <= satAdd16(evt_drop_cnt, dropInc);
    end
  end

endmodule
